uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 44 ++++
 rtl/uart_rx.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receiver and the transmitter.
//   uart_state_t    - frame FSM state encoding (3-bit binary)
//   PRESCALE_*      - legal oversampling ratios in clk cycles per bit
//   legal_prescale  - maps an unsupported ratio onto the default of 8
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        return (p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with 3-sample majority vote.
//   clk, rst  - clock, synchronous active-low reset
//   start     - start bit detected this cycle (counts as edge 0)
//   run       - frame in progress, keep counting
//   rx        - synchronised serial line
//   prescale  - latched clk cycles per bit
//   bit_val   - majority of samples at edges P/2-1, P/2, P/2+1
//   decide    - bit_val is valid this cycle (edge P/2+2)
//   last      - final edge of the current bit (edge P-1)
module uart_rx_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    input  logic       rx,
    input  logic [5:0] prescale,
    output logic       bit_val,
    output logic       decide,
    output logic       last
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [2:0] smp;

    assign half    = prescale >> 1;
    assign decide  = edge_cnt == half + 6'd2;
    assign last    = edge_cnt == prescale - 6'd1;
    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt <= '0;
            smp      <= '0;
        end else begin
            // the detection cycle was edge 0, so the first counted cycle is edge 1
            edge_cnt <= start ? 6'd1 : (run && !last) ? edge_cnt + 6'd1 : 6'd0;
            if (edge_cnt == half - 6'd1) smp[0] <= rx;
            if (edge_cnt == half)        smp[1] <= rx;
            if (edge_cnt == half + 6'd1) smp[2] <= rx;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and error flags.
//   clk, rst     - clock, synchronous active-low reset
//   RX_IN        - serial line, idle high, already synchronised
//   PAR_EN       - frame carries a parity bit
//   PAR_TYP      - 0 even, 1 odd parity
//   Prescale     - clk cycles per bit (8/16/32, others treated as 8)
//   P_DATA       - last correctly received character
//   data_valid   - one-cycle pulse when P_DATA updates
//   par_err      - parity mismatch on current/last frame
//   stp_err      - stop bit low on current/last frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic [5:0]            presc;
    logic                  bit_val;
    logic                  decide;
    logic                  last;
    logic                  start;

    assign start = state == IDLE && !RX_IN;

    uart_rx_sampler sampler (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .run      (state != IDLE),
        .rx       (RX_IN),
        .prescale (presc),
        .bit_val  (bit_val),
        .decide   (decide),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            presc       <= PRESCALE_8;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= START;
                    par_en_lat  <= PAR_EN;
                    par_typ_lat <= PAR_TYP;
                    presc       <= legal_prescale(Prescale);
                    par_err     <= 1'b0;
                    stp_err     <= 1'b0;
                end
                START: begin
                    if (decide && bit_val) state <= IDLE;
                    else if (last)         state <= DATA;
                end
                DATA: begin
                    if (decide) shift <= {bit_val, shift[DATA_WIDTH-1:1]};
                    if (last) begin
                        bit_cnt <= bit_cnt == BW'(DATA_WIDTH - 1) ? '0 : bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= par_en_lat ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) par_err <= bit_val != (^shift ^ par_typ_lat);
                    if (last)   state <= STOP;
                end
                STOP: begin
                    if (decide && !bit_val) stp_err <= 1'b1;
                    if (last) begin
                        state <= IDLE;
                        if (!par_err && !stp_err) begin
                            P_DATA     <= shift;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
